// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard: tracks destination locks and memory-port busy
// between launch and write-back, with a flush-drain state machine.
module reg_lock_tracker #(
  parameter int NR  = 64,
  parameter int NWB = 2,
  parameter int NOS = 8,
  localparam int RW = $clog2(NR),
  localparam int CW = $clog2(NOS + 1)
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    clear_i,
  input  logic                    launch_valid_i,
  input  logic                    launch_ready_i,
  input  logic                    launch_wr_i,
  input  logic [RW-1:0]           launch_rd_i,
  input  logic                    launch_mem_i,
  input  logic [NWB-1:0]          wb_valid_i,
  input  logic [NWB-1:0][RW-1:0]  wb_rd_i,
  input  logic                    mem_done_i,
  output logic [NR-1:0]           locks_o,
  output logic                    mem_busy_o,
  output logic [CW-1:0]           outstanding_o,
  output logic                    full_o,
  output logic                    drain_busy_o,
  output logic                    err_o
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [NR-1:0] locks_q, locks_d;
  logic [NR-1:0] set_vec, clr_vec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rise, fall;
  logic          mem_q, mem_d;
  logic          err_q, err_d;
  logic          hs, full, eff, do_set;
  logic          wb_err, dup, rd_clr, first;

  always_comb begin
    hs      = launch_valid_i & launch_ready_i;
    full    = (cnt_q == CW'(NOS));
    eff     = hs & (state_q == RUN) & ~full;
    do_set  = eff & launch_wr_i & (launch_rd_i != '0);
    set_vec = '0;
    clr_vec = '0;
    fall    = '0;
    wb_err  = 1'b0;
    dup     = 1'b0;
    rd_clr  = 1'b0;
    first   = 1'b0;
    if (do_set) set_vec[launch_rd_i] = 1'b1;
    for (int k = 0; k < NWB; k++) begin
      if (wb_valid_i[k] && wb_rd_i[k] != '0) begin
        clr_vec[wb_rd_i[k]] = 1'b1;
        if (!locks_q[wb_rd_i[k]]) wb_err = 1'b1;
        if (wb_rd_i[k] == launch_rd_i) rd_clr = 1'b1;
        first = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (wb_valid_i[j] && wb_rd_i[j] == wb_rd_i[k]) begin
            first = 1'b0;
            dup   = 1'b1;
          end
        end
        // A clear only counts if the bit really falls: first port
        // naming it, currently locked, and not re-set this cycle.
        if (first && locks_q[wb_rd_i[k]] &&
            !(do_set && launch_rd_i == wb_rd_i[k]))
          fall = fall + CW'(1);
      end
    end
    rise    = (do_set && !locks_q[launch_rd_i]) ? CW'(1) : '0;
    locks_d = (locks_q & ~clr_vec) | set_vec;
    cnt_d   = cnt_q + rise - fall;
    err_d   = err_q
            | (hs & full)
            | (hs & launch_wr_i & locks_q[launch_rd_i] & ~rd_clr)
            | wb_err
            | dup
            | (mem_done_i & ~mem_q);
    if (eff && launch_mem_i) mem_d = 1'b1;
    else if (mem_done_i)     mem_d = 1'b0;
    else                     mem_d = mem_q;
    state_d = state_q;
    unique case (state_q)
      RUN:   if (clear_i) state_d = DRAIN;
      DRAIN: if (!clear_i && cnt_q == '0 && !mem_q) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= RUN;
      locks_q <= '0;
      cnt_q   <= '0;
      mem_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      locks_q <= locks_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      err_q   <= err_d;
    end
  end

  assign locks_o       = locks_q;
  assign mem_busy_o    = mem_q;
  assign outstanding_o = cnt_q;
  assign full_o        = (cnt_q == CW'(NOS));
  assign drain_busy_o  = (state_q == DRAIN);
  assign err_o         = err_q;

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Bench for reg_lock_tracker: directed scenarios plus randomized traffic
// checked every cycle against a set-based reference model.
module tb_reg_lock_tracker;

  localparam int NR  = 64;
  localparam int NWB = 2;
  localparam int NOS = 8;
  localparam int RW  = 6;
  localparam int CW  = 4;

  logic                   clk = 1'b0;
  logic                   srst, clear, lv, lr, lwr, lmem, mdone;
  logic [RW-1:0]          lrd;
  logic [NWB-1:0]         wbv;
  logic [NWB-1:0][RW-1:0] wbrd;
  logic [NR-1:0]          locks_o;
  logic                   mem_busy_o, full_o, drain_busy_o, err_o;
  logic [CW-1:0]          outstanding_o;

  int n_chk = 0;
  int n_fail = 0;

  bit m_lk[NR];
  bit m_mem, m_drain, m_err;

  always #5 clk = ~clk;

  reg_lock_tracker #(.NR(NR), .NWB(NWB), .NOS(NOS)) dut (
    .clk_i(clk), .srst_i(srst), .clear_i(clear),
    .launch_valid_i(lv), .launch_ready_i(lr),
    .launch_wr_i(lwr), .launch_rd_i(lrd), .launch_mem_i(lmem),
    .wb_valid_i(wbv), .wb_rd_i(wbrd), .mem_done_i(mdone),
    .locks_o(locks_o), .mem_busy_o(mem_busy_o),
    .outstanding_o(outstanding_o), .full_o(full_o),
    .drain_busy_o(drain_busy_o), .err_o(err_o)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    foreach (m_lk[i]) c += int'(m_lk[i]);
    return c;
  endfunction

  task automatic idle();
    srst = 0; clear = 0; lv = 0; lr = 0; lwr = 0; lrd = '0;
    lmem = 0; mdone = 0; wbv = '0; wbrd = '0;
  endtask

  task automatic launch(int rd, bit mem);
    lv = 1; lr = 1; lwr = 1; lrd = RW'(rd); lmem = mem;
  endtask

  // Next model state from the rules, applied to current inputs.
  task automatic model_step();
    bit n_lk[NR];
    bit hs, full, eff, e, cl;
    int c;
    if (srst) begin
      foreach (m_lk[i]) m_lk[i] = 0;
      m_mem = 0; m_drain = 0; m_err = 0;
      return;
    end
    c = m_cnt();
    full = (c == NOS);
    hs = lv && lr;
    eff = hs && !m_drain && !full;
    e = m_err;
    if (hs && full) e = 1;
    if (hs && lwr && m_lk[lrd]) begin
      cl = 0;
      for (int k = 0; k < NWB; k++)
        if (wbv[k] && wbrd[k] == lrd) cl = 1;
      if (!cl) e = 1;
    end
    for (int k = 0; k < NWB; k++) begin
      if (wbv[k] && wbrd[k] != 0) begin
        if (!m_lk[wbrd[k]]) e = 1;
        for (int j = 0; j < k; j++)
          if (wbv[j] && wbrd[j] == wbrd[k]) e = 1;
      end
    end
    if (mdone && !m_mem) e = 1;
    n_lk = m_lk;
    for (int k = 0; k < NWB; k++)
      if (wbv[k] && wbrd[k] != 0) n_lk[wbrd[k]] = 0;
    if (eff && lwr && lrd != 0) n_lk[lrd] = 1;
    if (!m_drain) m_drain = clear;
    else if (!clear && c == 0 && !m_mem) m_drain = 0;
    if (eff && lmem) m_mem = 1;
    else if (mdone) m_mem = 0;
    m_lk = n_lk;
    m_err = e;
  endtask

  task automatic step_check();
    logic [NR-1:0] exp;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) exp[i] = m_lk[i];
    check("locks", locks_o, exp);
    check("mem_busy", mem_busy_o, m_mem);
    check("outstanding", outstanding_o, m_cnt());
    check("full", full_o, m_cnt() == NOS);
    check("drain_busy", drain_busy_o, m_drain);
    check("err", err_o, m_err);
  endtask

  task automatic do_reset();
    idle(); srst = 1;
    step_check();
    srst = 0;
  endtask

  initial begin
    int q[$];
    idle();
    srst = 1;
    @(posedge clk); #1;
    do_reset();

    // reset mid-traffic
    launch(3, 0); step_check();
    launch(5, 1); step_check();
    launch(9, 0); clear = 1; wbv = 2'b11; wbrd[0] = 3; wbrd[1] = 5;
    mdone = 1; srst = 1;
    step_check();
    check("rst_locks", locks_o, 0);
    check("rst_mem", mem_busy_o, 0);
    check("rst_drain", drain_busy_o, 0);
    check("rst_cnt", outstanding_o, 0);

    // basic lock / release
    idle(); launch(7, 0); step_check();
    check("lock7", locks_o[7], 1);
    check("lock7_cnt", outstanding_o, 1);
    idle(); step_check();
    wbv = 2'b10; wbrd[1] = 7; step_check();
    check("unlock7", locks_o[7], 0);
    idle(); launch(0, 0); step_check();
    check("rd0", locks_o, 0);

    // simultaneous set and clear
    idle(); launch(9, 0); step_check();
    launch(9, 0); wbv = 2'b01; wbrd[0] = 9; step_check();
    check("setclr_lock", locks_o[9], 1);
    check("setclr_cnt", outstanding_o, 1);
    check("setclr_err", err_o, 0);

    // full
    do_reset();
    for (int r = 1; r <= 8; r++) begin
      idle(); launch(r, 0); step_check();
    end
    check("full_set", full_o, 1);
    idle(); launch(10, 0); step_check();
    check("full_drop", locks_o[10], 0);
    check("full_err", err_o, 1);
    idle(); wbv = 2'b01; wbrd[0] = 1; step_check();
    check("full_clr", full_o, 0);
    idle(); launch(1, 0); step_check();
    idle(); launch(11, 0); wbv = 2'b01; wbrd[0] = 2; step_check();
    check("full_wb_drop", locks_o[11], 0);
    check("full_wb_cnt", outstanding_o, 7);

    // drain
    do_reset();
    launch(2, 1); step_check();
    idle(); launch(4, 0); step_check();
    idle(); clear = 1; step_check();
    check("drain_on", drain_busy_o, 1);
    idle(); launch(6, 0); step_check();
    check("drain_drop", locks_o[6], 0);
    idle(); wbv = 2'b11; wbrd[0] = 2; wbrd[1] = 4; step_check();
    idle(); mdone = 1; step_check();
    check("drain_hold", drain_busy_o, 1);
    idle(); step_check();
    check("drain_off", drain_busy_o, 0);
    check("drain_err", err_o, 0);

    // drain with nothing outstanding
    idle(); clear = 1; step_check();
    idle(); step_check();
    check("drain_empty", drain_busy_o, 1'b0);

    // dual write-back
    do_reset();
    launch(12, 0); step_check();
    idle(); wbv = 2'b11; wbrd[0] = 12; wbrd[1] = 12; step_check();
    check("dual_lock", locks_o[12], 0);
    check("dual_cnt", outstanding_o, 0);
    check("dual_err", err_o, 1);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      srst  = ($urandom % 64) == 0;
      clear = ($urandom % 20) == 0;
      lv    = ($urandom % 2) == 0;
      lr    = ($urandom % 4) != 0;
      lwr   = ($urandom % 4) != 0;
      lmem  = ($urandom % 6) == 0;
      lrd   = RW'($urandom % 16);
      q.delete();
      foreach (m_lk[i]) if (m_lk[i]) q.push_back(i);
      for (int k = 0; k < NWB; k++) begin
        wbv[k] = ($urandom % 3) == 0;
        if (q.size() > 0 && ($urandom % 4) != 0)
          wbrd[k] = RW'(q[$urandom % q.size()]);
        else
          wbrd[k] = RW'($urandom % 16);
      end
      mdone = m_mem ? (($urandom % 4) == 0) : (($urandom % 50) == 0);
      step_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
